// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver, LSB first, idle-high line.
//
// The asynchronous rx pin goes through a two-flop synchronizer. A falling
// edge seen in IDLE starts a frame. The start bit is confirmed at its
// mid-point. The eight data bits and the stop bit are then sampled exactly
// CLKS_PER_BIT cycles apart, so every sample lands near the middle of its bit.
//
// Ports
//   clk_3125KHz : the only clock; all logic is on its rising edge
//   reset       : synchronous, active-high reset
//   rx          : asynchronous serial input
//   rx_msg      : last correctly framed byte; held until the next good byte
//   rx_complete : one-cycle pulse in the cycle rx_msg has just been updated
//   frame_err   : one-cycle pulse when the stop bit was sampled low
//   rx_busy     : high whenever the receiver is not in IDLE
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int CLKS_PER_BIT = 27,
  parameter int HALF_BIT     = 13
) (
  input  logic       clk_3125KHz,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_msg,
  output logic       rx_complete,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_CLEANUP = 3'd4,
    S_BREAK   = 3'd5
  } state_t;

  state_t           r_state,     w_state_next;
  logic [CNT_W-1:0] r_cnt,       w_cnt_next;
  logic [2:0]       r_bit_idx,   w_bit_idx_next;
  logic [7:0]       r_shift,     w_shift_next;
  logic [7:0]       r_msg,       w_msg_next;
  logic             r_complete,  w_complete_next;
  logic             r_frame_err, w_frame_err_next;
  logic             r_sync1,     r_sync2;

  // Synchronizer resets to the idle (high) level so that reset never
  // manufactures a start edge.
  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk_3125KHz) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit_idx   <= '0;
      r_shift     <= 8'h00;
      r_msg       <= 8'h00;
      r_complete  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_cnt       <= w_cnt_next;
      r_bit_idx   <= w_bit_idx_next;
      r_shift     <= w_shift_next;
      r_msg       <= w_msg_next;
      r_complete  <= w_complete_next;
      r_frame_err <= w_frame_err_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_cnt_next       = r_cnt;
    w_bit_idx_next   = r_bit_idx;
    w_shift_next     = r_shift;
    w_msg_next       = r_msg;
    w_complete_next  = 1'b0;
    w_frame_err_next = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_next     = '0;
        w_bit_idx_next = '0;
        if (!r_sync2) begin
          w_state_next = S_START;
        end
      end

      // A start bit that is no longer low at its mid-point was a glitch.
      S_START: begin
        if (r_cnt == CNT_HALF) begin
          w_cnt_next     = '0;
          w_bit_idx_next = '0;
          w_state_next   = r_sync2 ? S_IDLE : S_DATA;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      // The counter restarts at the start-bit mid-point, so each sample
      // taken at CNT_LAST falls a whole bit period later, mid-bit.
      S_DATA: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next              = '0;
          w_shift_next[r_bit_idx] = r_sync2;
          if (r_bit_idx == 3'd7) begin
            w_bit_idx_next = '0;
            w_state_next   = S_STOP;
          end else begin
            w_bit_idx_next = r_bit_idx + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (r_cnt == CNT_LAST) begin
          w_cnt_next = '0;
          if (r_sync2) begin
            w_msg_next      = r_shift;
            w_complete_next = 1'b1;
            w_state_next    = S_CLEANUP;
          end else begin
            w_frame_err_next = 1'b1;
            w_state_next     = S_BREAK;
          end
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end

      // One cycle only, so a start bit that follows the stop bit with no
      // gap is still caught in IDLE.
      S_CLEANUP: begin
        w_state_next = S_IDLE;
      end

      // A line held low after a bad stop bit must not be re-framed.
      S_BREAK: begin
        if (r_sync2) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign rx_msg      = r_msg;
  assign rx_complete = r_complete;
  assign frame_err   = r_frame_err;
  assign rx_busy     = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
//
// A behavioural model follows the receiver's timing rules: it times every
// sample from the cycle that first saw the synchronized line low. A compare
// process checks all outputs against the model on every cycle. Directed
// checks with hand-computed literals pin down the model itself.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int C = 27;
  localparam int H = 13;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic       rx    = 1'b1;
  logic [7:0] rx_msg;
  logic       rx_complete;
  logic       frame_err;
  logic       rx_busy;

  uart_rx #(.CLKS_PER_BIT(C), .HALF_BIT(H)) dut (
    .clk_3125KHz (clk),
    .reset       (reset),
    .rx          (rx),
    .rx_msg      (rx_msg),
    .rx_complete (rx_complete),
    .frame_err   (frame_err),
    .rx_busy     (rx_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // ---------------- behavioural model ----------------
  typedef enum {M_IDLE, M_FRAME, M_CLEAN, M_BREAK} mphase_t;
  mphase_t    m_phase    = M_IDLE;
  int         m_t        = 0;
  logic       m_s1       = 1'b1;
  logic       m_s2       = 1'b1;
  logic [7:0] m_data     = 8'h00;
  logic [7:0] m_msg      = 8'h00;
  logic       m_complete = 1'b0;
  logic       m_ferr     = 1'b0;
  logic       m_busy     = 1'b0;

  // Sample k (1..8 data, 9 stop) happens at H+1+k*C cycles after the
  // cycle that first saw the synchronized line low; start is checked at H+1.
  always @(posedge clk) begin : model
    logic line;
    int   k;
    cyc++;
    m_complete = 1'b0;
    m_ferr     = 1'b0;
    if (reset) begin
      m_phase = M_IDLE;
      m_s1    = 1'b1;
      m_s2    = 1'b1;
      m_data  = 8'h00;
      m_msg   = 8'h00;
    end else begin
      line = m_s2;
      case (m_phase)
        M_IDLE: if (!line) begin m_phase = M_FRAME; m_t = 0; end
        M_FRAME: begin
          m_t++;
          if (m_t == H + 1) begin
            if (line) m_phase = M_IDLE;
          end else if (m_t > H + 1 && ((m_t - H - 1) % C) == 0) begin
            k = (m_t - H - 1) / C;
            if (k <= 8) begin
              m_data[k-1] = line;
            end else if (line) begin
              m_msg      = m_data;
              m_complete = 1'b1;
              m_phase    = M_CLEAN;
            end else begin
              m_ferr  = 1'b1;
              m_phase = M_BREAK;
            end
          end
        end
        M_CLEAN: m_phase = M_IDLE;
        M_BREAK: if (line) m_phase = M_IDLE;
        default: m_phase = M_IDLE;
      endcase
      m_s2 = m_s1;
      m_s1 = rx;
    end
    m_busy = (m_phase != M_IDLE);
  end

  // ---------------- per-cycle compare ----------------
  bit         chk_en            = 1'b0;
  int         n_complete        = 0;
  int         n_ferr            = 0;
  int         last_complete_cyc = 0;
  int         n_prints          = 0;
  logic [7:0] got_q[$];

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (rx_complete !== m_complete || frame_err !== m_ferr ||
          rx_msg !== m_msg || rx_busy !== m_busy) begin
        errors++;
        if (n_prints < 20) begin
          n_prints++;
          $display("FAIL model cyc=%0d got cmp=%b ferr=%b msg=%02h busy=%b need cmp=%b ferr=%b msg=%02h busy=%b",
                   cyc, rx_complete, frame_err, rx_msg, rx_busy,
                   m_complete, m_ferr, m_msg, m_busy);
        end
      end
      if (rx_complete === 1'b1) begin
        n_complete++;
        last_complete_cyc = cyc;
        got_q.push_back(rx_msg);
      end
      if (frame_err === 1'b1) n_ferr++;
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", name, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", name, got);
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic v, input int cpb);
    rx = v;
    repeat (cpb) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int cpb, input logic stop);
    send_bit(1'b0, cpb);
    for (int i = 0; i < 8; i++) send_bit(b[i], cpb);
    send_bit(stop, cpb);
  endtask

  // ---------------- directed stimulus ----------------
  logic [7:0] b2b [6] = '{8'h49, 8'h46, 8'h4D, 8'h2D, 8'h45, 8'h23};

  initial begin : stim
    int         t_start;
    int         lat;
    int         c0;
    int         f0;
    logic [7:0] v55;

    reset = 1'b1;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("reset_msg",      rx_msg,      32'h00);
    check("reset_complete", rx_complete, 32'h0);
    check("reset_ferr",     frame_err,   32'h0);
    check("reset_busy",     rx_busy,     32'h0);
    reset = 1'b0;
    idle(10);

    // 0x49 at nominal baud, with latency from the pin-level start edge
    c0 = n_complete; f0 = n_ferr;
    t_start = cyc + 1;
    send_byte(8'h49, C, 1'b1);
    idle(20);
    lat = last_complete_cyc - t_start;
    $display("tx 0x49 latency=%0d cycles", lat);
    check("byte49_msg",     rx_msg,          32'h49);
    check("byte49_pulses",  n_complete - c0, 32'd1);
    check("byte49_ferr",    n_ferr - f0,     32'd0);
    check("byte49_latency", (lat >= 259 && lat <= 261), 32'd1);

    // 5-cycle glitch on the idle line
    c0 = n_complete; f0 = n_ferr;
    t_start = cyc + 1;
    rx = 1'b0;
    repeat (5) @(negedge clk);
    check("glitch_busy_seen", rx_busy, 32'h1);
    rx = 1'b1;
    repeat (13) @(negedge clk);
    check("glitch_busy_clear", rx_busy, 32'h0);
    idle(20);
    check("glitch_pulses", n_complete - c0, 32'd0);
    check("glitch_ferr",   n_ferr - f0,     32'd0);
    check("glitch_msg",    rx_msg,          32'h49);

    // 0x23 with a low stop bit, then the line held low
    c0 = n_complete; f0 = n_ferr;
    send_byte(8'h23, C, 1'b0);
    rx = 1'b0;
    repeat (100) @(negedge clk);
    check("break_busy_held", rx_busy, 32'h1);
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check("break_busy_clear", rx_busy,         32'h0);
    check("break_ferr",       n_ferr - f0,     32'd1);
    check("break_pulses",     n_complete - c0, 32'd0);
    check("break_msg",        rx_msg,          32'h49);
    idle(20);

    // "IFM-E#" back-to-back, zero idle gap between frames
    c0 = n_complete; f0 = n_ferr;
    got_q.delete();
    for (int i = 0; i < 6; i++) send_byte(b2b[i], C, 1'b1);
    idle(40);
    check("b2b_pulses", n_complete - c0, 32'd6);
    check("b2b_ferr",   n_ferr - f0,     32'd0);
    for (int i = 0; i < 6; i++) begin
      if (i < got_q.size()) check($sformatf("b2b_byte%0d", i), got_q[i], b2b[i]);
      else check($sformatf("b2b_byte%0d_missing", i), 32'd0, 32'd1);
    end

    // reset pulse in the middle of data bit 4 of 0x55
    c0 = n_complete; f0 = n_ferr;
    v55 = 8'h55;
    send_bit(1'b0, C);
    for (int i = 0; i < 4; i++) send_bit(v55[i], C);
    rx = v55[4];
    repeat (13) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_msg_zero", rx_msg,  32'h00);
    check("abort_busy",     rx_busy, 32'h0);
    repeat (C - 14) @(negedge clk);
    for (int i = 5; i < 8; i++) send_bit(v55[i], C);
    send_bit(1'b1, C);
    repeat (3) @(negedge clk);
    check("abort_no_pulse", n_complete - c0, 32'd0);
    check("abort_no_ferr",  n_ferr - f0,     32'd0);
    // The low bit 5 is taken as a fresh start edge. That frame reads bit 6,
    // bit 7, the stop bit and then idle-high: 1,0,1,1,1,1,1,1 -> 0xFD.
    idle(200);
    check("abort_reframe_msg", rx_msg, 32'hFD);
    c0 = n_complete; f0 = n_ferr;
    send_byte(8'hA5, C, 1'b1);
    idle(20);
    check("a5_msg",    rx_msg,          32'hA5);
    check("a5_pulses", n_complete - c0, 32'd1);
    check("a5_ferr",   n_ferr - f0,     32'd0);

    // +/-2 % baud deviation
    c0 = n_complete; f0 = n_ferr;
    send_byte(8'h3C, 26, 1'b1);
    idle(30);
    check("fast_msg", rx_msg, 32'h3C);
    send_byte(8'hC3, 28, 1'b1);
    idle(30);
    check("slow_msg",    rx_msg,          32'hC3);
    check("skew_pulses", n_complete - c0, 32'd2);
    check("skew_ferr",   n_ferr - f0,     32'd0);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLKS_PER_BIT, default 27, is the number of clk_3125KHz cycles per UART bit (3.125 MHz / 115200 baud, rounded).
REQ-002 Parameter HALF_BIT, default 13 (= (CLKS_PER_BIT-1)/2), is the start-bit mid-point offset in cycles.
REQ-003 Port clk_3125KHz, input, 1 bit: the only clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 Port rx, input, 1 bit: asynchronous serial line, 8N1 framing, LSB first, idle high.
REQ-006 Port rx_msg, output, 8 bits: last correctly framed byte, held until the next good byte.
REQ-007 Port rx_complete, output, 1 bit: one-cycle pulse when rx_msg has just been updated.
REQ-008 Port frame_err, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-009 Port rx_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer (rx_sync) before any use; rx_sync SHALL reset to 1.
REQ-011 States SHALL be IDLE, START, DATA, STOP, CLEANUP and BREAK, with a cycle counter (0..CLKS_PER_BIT-1) and a bit index (0..7).
REQ-012 IDLE: when rx_sync==0, go to START with counter=0; otherwise stay in IDLE.
REQ-013 START: increment the counter each cycle; at counter==HALF_BIT, sample rx_sync.
  - If rx_sync==0: go to DATA with counter=0 and bit index=0.
  - If rx_sync==1 (glitch): return to IDLE with no output pulse.
REQ-014 DATA: at counter==CLKS_PER_BIT-1, sample rx_sync into shift-register bit [bit index] (LSB first) and clear the counter; after bit index 7, go to STOP.
REQ-015 STOP: at counter==CLKS_PER_BIT-1, sample rx_sync.
  - If 1: load rx_msg from the shift register, pulse rx_complete, go to CLEANUP.
  - If 0: leave rx_msg unchanged, pulse frame_err, go to BREAK.
REQ-016 CLEANUP SHALL last exactly one cycle, then go to IDLE.
REQ-017 BREAK SHALL wait until rx_sync==1, then go to IDLE; a line held low SHALL NOT produce further frames.
REQ-018 Sample points SHALL be exactly CLKS_PER_BIT cycles apart.
  - The first data-bit sample SHALL occur HALF_BIT+1+CLKS_PER_BIT cycles after the IDLE cycle that saw rx_sync==0.
  - The stop-bit sample SHALL occur at cycle +1+HALF_BIT+9*(CLKS_PER_BIT) from that same IDLE cycle.
REQ-019 rx_msg, rx_complete and frame_err SHALL be registered.
  - rx_complete and frame_err SHALL rise in the cycle after the stop-bit sample edge.
  - rx_complete and frame_err SHALL never be high in the same cycle.
REQ-020 With the defaults, rx_complete SHALL rise 258 cycles after the IDLE cycle that first saw rx_sync==0, i.e. 260 cycles after rx is first sampled low at the pin.
REQ-021 Back-to-back frames with no idle gap between stop bit and next start bit SHALL all be received, because CLEANUP and IDLE together consume 2 cycles of the stop bit's remaining half-bit.
REQ-022 The counter SHALL NOT exceed CLKS_PER_BIT-1, and the bit index SHALL NOT wrap inside DATA.
REQ-023 rx_msg SHALL be stable while rx_complete is high and SHALL remain stable until the next rx_complete.
REQ-024 There is no backpressure: the consumer SHALL latch rx_msg on rx_complete, and an unconsumed byte is overwritten by the next good frame.

Reset
REQ-025 While reset is high at a clock edge, the block SHALL take these values and shall ignore rx:
  - state=IDLE, counter=0, bit index=0
  - shift register=0x00, rx_msg=0x00
  - rx_complete=0, frame_err=0, rx_busy=0
  - both synchronizer flops=1
REQ-026 Reset asserted mid-frame SHALL abort the frame with no rx_complete or frame_err pulse.
  - After release, the block SHALL wait in IDLE for a new falling edge.
  - The remaining bits of the aborted frame SHALL be interpreted only as new start edges if low.

Verification
REQ-027 Drive 0x49 ('I'), 8N1, 27 cycles/bit, after reset -> rx_msg=0x49, rx_complete high for exactly 1 cycle, 260±1 cycles after the start edge at the pin, frame_err=0.
REQ-028 Drive a 5-cycle low glitch on idle rx -> no rx_complete, no frame_err; rx_busy returns to 0 within 16 cycles; rx_msg unchanged.
REQ-029 Send 0x23 with the stop bit forced low, then hold rx low for 100 cycles, then release -> one frame_err pulse; rx_msg keeps its prior value; no rx_complete; state IDLE after rx returns high.
REQ-030 Send "IFM-E#" (0x49 0x46 0x4D 0x2D 0x45 0x23) back-to-back with zero gap -> six rx_complete pulses with rx_msg in that order and no frame_err.
REQ-031 Assert reset for 1 cycle during data bit 4 of 0x55, then send 0xA5 cleanly -> no pulse for the aborted frame; after reset rx_msg=0x00; then rx_msg=0xA5 with a single rx_complete.
REQ-032 Send a byte at ±2% baud deviation (26 and 28 cycles/bit) -> byte received correctly in both cases.
